fetch_pc_gen: RTL and testbench
===============================

// Module: fetch_pc_gen
// PURPOSE
//  Fetch-stage next-PC generator with a direct-mapped branch target buffer (BTB).
//  Sits directly upstream of the 2-bit branch predictor: drives fetch_pc_o into the predictor's fetch PC input.
//  Consumes the predictor's taken bit and steers the next fetch to the BTB target on (hit && taken).
//  Takes redirect and BTB updates from execute.
// PARAMETERS
//  BTB_ENTRIES  16            BTB depth, power of 2, >=2; index = pc[$clog2(BTB_ENTRIES)+1:2]
//  RESET_PC     32'h0000_0000 first fetch address after reset; bits[1:0] must be 0
// PORTS
//  clk              in   1   clock, all state updates on posedge
//  rst_n            in   1   asynchronous, active-low reset
//  stall_i          in   1   hold current fetch PC (downstream not ready)
//  predict_taken_i  in   1   predictor direction for current fetch_pc_o (combinational)
//  redirect_i       in   1   execute mispredict/jump: refetch from redirect_pc_i
//  redirect_pc_i    in   32  corrected PC
//  upd_valid_i      in   1   execute resolved a branch/jump this cycle
//  upd_pc_i         in   32  PC of resolved instruction
//  upd_target_i     in   32  resolved target address
//  upd_taken_i      in   1   resolved direction
//  fetch_pc_o       out  32  current fetch address (registered)
//  fetch_valid_o    out  1   fetch_pc_o is a real fetch
//  pred_taken_o     out  1   btb_hit && predict_taken_i (combinational)
//  pred_target_o    out  32  BTB target on hit, else fetch_pc_o+4 (combinational)
//  perf_hit_cnt_o   out  32  taken-predicted fetches (see CONFIGURATION)
//  perf_redir_cnt_o out  32  accepted redirects (see CONFIGURATION)
// BEHAVIOUR
//  Reset (rst_n=0, async): fetch_pc_o=RESET_PC, fetch_valid_o=0, state=BOOT, all BTB valid bits=0, counters=0.
//  FSM: BOOT -> RUN on the first clk edge with rst_n=1; no other exit.
//   - BOOT: fetch_valid_o=0, PC held at RESET_PC.
//   - RUN: fetch_valid_o=1.
//   - RUN -> BOOT only via reset; reset mid-operation aborts everything immediately.
//  BTB entry: {valid, tag=pc[31:IDX+2], target[31:2]}; stored target[1:0] forced to 00.
//  btb_hit = entry[idx(fetch_pc_o)].valid && tag match; pure combinational read.
//  Next PC in RUN, priority high->low:
//   1. redirect_i -> redirect_pc_i (with [1:0] cleared).
//   2. stall_i -> hold.
//   3. pred_taken_o -> BTB target.
//   4. otherwise -> fetch_pc_o+4 (32-bit wrap: 32'hFFFF_FFFC -> 0).
//  Latency: one cycle from redirect_i to fetch_pc_o==redirect_pc_i. redirect_i in BOOT is ignored.
//  Update: upd_valid_i && upd_taken_i writes entry[idx(upd_pc_i)] = {1, tag, upd_target_i[31:2]}, overwriting any alias.
//   - Not-taken update leaves the entry unchanged.
//   - Update is independent of stall_i/redirect_i.
//  Same-cycle update and lookup on one index: lookup sees pre-write contents; the write is visible next cycle.
//  pred_* outputs are valid only when fetch_valid_o=1; they are driven 0 / PC+4 in BOOT.
// CONFIGURATION
//  FETCH_PERF_CNT_EN defined:
//   - perf_hit_cnt_o +1 each RUN cycle with pred_taken_o && !stall_i && !redirect_i.
//   - perf_redir_cnt_o +1 per accepted redirect.
//   - Both saturate at 32'hFFFF_FFFF; both reset to 0.
//  Not defined: no counter flops; both outputs tied to 32'h0.
// TESTING
//  1. Reset with RESET_PC=32'h100, release -> one cycle valid=0 at 0x100, then 0x100,0x104,0x108 with valid=1.
//  2. upd taken pc=0x108 tgt=0x200, predict_taken_i=1 at 0x108 -> pred_taken_o=1, next PC 0x200; with predict_taken_i=0 -> 0x10C.
//  3. stall_i=1 and redirect_i=1 with redirect_pc_i=0x400 same cycle -> next fetch_pc_o=0x400.
//  4. Alias: BTB_ENTRIES=16, entry for 0x108 installed, fetch 0x148 (same idx, diff tag) -> pred_taken_o=0, next 0x14C.
//  5. Update 0x108->0x300 in same cycle fetch is at 0x108 -> old target used this cycle; next visit uses 0x300.
//  6. FETCH_PERF_CNT_EN: 3 redirects + 2 taken hits -> perf_redir_cnt_o=3, perf_hit_cnt_o=2; assert rst_n=0 mid-run -> all zero, PC=RESET_PC immediately.

Source files
------------

// File: rtl/fetch_pc_gen.sv
// Fetch-stage next-PC generator with a direct-mapped BTB, redirect and update paths from execute.
// Optional perf counters are built when FETCH_PERF_CNT_EN is defined; otherwise both counter outputs are tied to zero.
module fetch_pc_gen #(
    parameter int          BTB_ENTRIES = 16,
    parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic        predict_taken_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        upd_valid_i,
    input  logic [31:0] upd_pc_i,
    input  logic [31:0] upd_target_i,
    input  logic        upd_taken_i,
    output logic [31:0] fetch_pc_o,
    output logic        fetch_valid_o,
    output logic        pred_taken_o,
    output logic [31:0] pred_target_o,
    output logic [31:0] perf_hit_cnt_o,
    output logic [31:0] perf_redir_cnt_o
);
    localparam int IDX  = $clog2(BTB_ENTRIES);
    localparam int TAGW = 30 - IDX;

    typedef enum logic {BOOT, RUN} state_t;

    state_t                   r_state, w_state_nxt;
    logic [31:0]              r_pc, w_pc_nxt, w_pc_inc;
    logic [BTB_ENTRIES-1:0]   r_btb_vld;
    logic [TAGW-1:0]          r_btb_tag [BTB_ENTRIES];
    logic [29:0]              r_btb_tgt [BTB_ENTRIES];
    logic [IDX-1:0]           w_rd_idx, w_wr_idx;
    logic                     w_run, w_hit, w_upd;
    logic                     w_unused;

    assign w_rd_idx = r_pc[IDX+1:2];
    assign w_wr_idx = upd_pc_i[IDX+1:2];
    assign w_run    = (r_state == RUN);
    assign w_hit    = r_btb_vld[w_rd_idx] && (r_btb_tag[w_rd_idx] == r_pc[31:IDX+2]);
    assign w_upd    = upd_valid_i && upd_taken_i;
    assign w_pc_inc = r_pc + 32'd4;
    assign w_unused = &{1'b0, upd_pc_i[1:0], upd_target_i[1:0], redirect_pc_i[1:0]};

    assign fetch_pc_o    = r_pc;
    assign fetch_valid_o = w_run;
    assign pred_taken_o  = w_run && w_hit && predict_taken_i;
    assign pred_target_o = (w_run && w_hit) ? {r_btb_tgt[w_rd_idx], 2'b00} : w_pc_inc;

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        case (r_state)
            BOOT: w_state_nxt = RUN;
            RUN: begin
                if (redirect_i)        w_pc_nxt = {redirect_pc_i[31:2], 2'b00};
                else if (stall_i)      w_pc_nxt = r_pc;
                else if (pred_taken_o) w_pc_nxt = {r_btb_tgt[w_rd_idx], 2'b00};
                else                   w_pc_nxt = w_pc_inc;
            end
            default: w_state_nxt = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= BOOT;
            r_pc      <= RESET_PC;
            r_btb_vld <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            if (w_upd) r_btb_vld[w_wr_idx] <= 1'b1;
        end
    end

    // Payload needs no reset: it is only ever read behind a set valid bit.
    always_ff @(posedge clk) begin
        if (w_upd) begin
            r_btb_tag[w_wr_idx] <= upd_pc_i[31:IDX+2];
            r_btb_tgt[w_wr_idx] <= upd_target_i[31:2];
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_hit_cnt, r_redir_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hit_cnt   <= '0;
            r_redir_cnt <= '0;
        end else begin
            if (pred_taken_o && !stall_i && !redirect_i && r_hit_cnt != 32'hFFFF_FFFF)
                r_hit_cnt <= r_hit_cnt + 32'd1;
            if (w_run && redirect_i && r_redir_cnt != 32'hFFFF_FFFF)
                r_redir_cnt <= r_redir_cnt + 32'd1;
        end
    end

    assign perf_hit_cnt_o   = r_hit_cnt;
    assign perf_redir_cnt_o = r_redir_cnt;
`else
    assign perf_hit_cnt_o   = 32'h0;
    assign perf_redir_cnt_o = 32'h0;
`endif
endmodule

// File: tb/tb_fetch_pc_gen.sv
// Bench for fetch_pc_gen: directed vector table for boot/BTB/alias/stall/redirect/wrap, async reset, then random vs a reference model.
module tb_fetch_pc_gen;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall_i, predict_taken_i, redirect_i, upd_valid_i, upd_taken_i;
    logic [31:0] redirect_pc_i, upd_pc_i, upd_target_i;
    logic [31:0] fetch_pc_o, pred_target_o, perf_hit_cnt_o, perf_redir_cnt_o;
    logic        fetch_valid_o, pred_taken_o;

    int n_pass = 0;
    int n_total = 0;

    fetch_pc_gen #(.BTB_ENTRIES(16), .RESET_PC(32'h100)) dut (
        .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .predict_taken_i(predict_taken_i),
        .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i), .upd_valid_i(upd_valid_i),
        .upd_pc_i(upd_pc_i), .upd_target_i(upd_target_i), .upd_taken_i(upd_taken_i),
        .fetch_pc_o(fetch_pc_o), .fetch_valid_o(fetch_valid_o), .pred_taken_o(pred_taken_o),
        .pred_target_o(pred_target_o), .perf_hit_cnt_o(perf_hit_cnt_o),
        .perf_redir_cnt_o(perf_redir_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    typedef struct {
        bit          stall, ptk, redir;
        logic [31:0] rpc;
        bit          uv;
        logic [31:0] upc, utgt;
        bit          utk;
        logic [31:0] epc;
        bit          evld, eptk;
        logic [31:0] etgt;
    } vec_t;

    vec_t vecs[19];

    // Reference model: BTB as plain arrays, index/tag by division.
    bit          m_run;
    logic [31:0] m_pc;
    bit          m_v   [16];
    logic [31:0] m_tag [16];
    logic [31:0] m_tgt [16];
    logic [31:0] m_hit_cnt, m_redir_cnt;

    task automatic model_reset();
        m_run = 0; m_pc = 32'h100; m_hit_cnt = 0; m_redir_cnt = 0;
        for (int i = 0; i < 16; i++) m_v[i] = 0;
    endtask

    task automatic drive(input bit s, input bit p, input bit r, input logic [31:0] rp,
                         input bit uv, input logic [31:0] up, input logic [31:0] ut, input bit uk);
        stall_i = s; predict_taken_i = p; redirect_i = r; redirect_pc_i = rp;
        upd_valid_i = uv; upd_pc_i = up; upd_target_i = ut; upd_taken_i = uk;
    endtask

    initial begin
        logic [31:0] e_tgt, nxt;
        int          ix;
        bit          hit, e_ptk;
        logic [31:0] exp_hits, exp_redirs;

        vecs[0]  = '{0,0,1,32'h400,       0,0,0,0,                   32'h100,1'b0,0,32'h104};
        vecs[1]  = '{0,0,0,0,             0,0,0,0,                   32'h100,1,0,32'h104};
        vecs[2]  = '{0,0,0,0,             1,32'h108,32'h200,1,       32'h104,1,0,32'h108};
        vecs[3]  = '{0,1,0,0,             0,0,0,0,                   32'h108,1,1,32'h200};
        vecs[4]  = '{0,1,1,32'h108,       0,0,0,0,                   32'h200,1,0,32'h204};
        vecs[5]  = '{0,0,0,0,             0,0,0,0,                   32'h108,1,0,32'h200};
        vecs[6]  = '{1,0,1,32'h400,       0,0,0,0,                   32'h10C,1,0,32'h110};
        vecs[7]  = '{0,0,1,32'h14B,       0,0,0,0,                   32'h400,1,0,32'h404};
        vecs[8]  = '{0,1,0,0,             0,0,0,0,                   32'h148,1,0,32'h14C};
        vecs[9]  = '{1,0,0,0,             0,0,0,0,                   32'h14C,1,0,32'h150};
        vecs[10] = '{0,0,1,32'h108,       0,0,0,0,                   32'h14C,1,0,32'h150};
        vecs[11] = '{0,1,0,0,             1,32'h108,32'h302,1,       32'h108,1,1,32'h200};
        vecs[12] = '{0,0,1,32'h108,       0,0,0,0,                   32'h200,1,0,32'h204};
        vecs[13] = '{0,1,0,0,             0,0,0,0,                   32'h108,1,1,32'h300};
        vecs[14] = '{0,0,1,32'h108,       1,32'h108,32'h500,0,       32'h300,1,0,32'h304};
        vecs[15] = '{0,1,0,0,             0,0,0,0,                   32'h108,1,1,32'h300};
        vecs[16] = '{0,0,1,32'hFFFF_FFFC, 0,0,0,0,                   32'h300,1,0,32'h304};
        vecs[17] = '{0,0,0,0,             0,0,0,0,                   32'hFFFF_FFFC,1,0,32'h0};
        vecs[18] = '{0,0,0,0,             0,0,0,0,                   32'h0,1,0,32'h4};

        rst_n = 1'b0;
        drive(0,0,0,0,0,0,0,0);
        repeat (2) @(negedge clk);
        chk("reset_pc", fetch_pc_o, 32'h100);
        chk("reset_valid", {31'b0, fetch_valid_o}, 32'h0);
        chk("reset_hitcnt", perf_hit_cnt_o, 32'h0);
        chk("reset_redircnt", perf_redir_cnt_o, 32'h0);
        rst_n = 1'b1;

        for (int v = 0; v < 19; v++) begin
            drive(vecs[v].stall, vecs[v].ptk, vecs[v].redir, vecs[v].rpc,
                  vecs[v].uv, vecs[v].upc, vecs[v].utgt, vecs[v].utk);
            #1;
            chk($sformatf("v%0d_pc", v), fetch_pc_o, vecs[v].epc);
            chk($sformatf("v%0d_valid", v), {31'b0, fetch_valid_o}, {31'b0, vecs[v].evld});
            chk($sformatf("v%0d_ptaken", v), {31'b0, pred_taken_o}, {31'b0, vecs[v].eptk});
            chk($sformatf("v%0d_ptarget", v), pred_target_o, vecs[v].etgt);
            @(negedge clk);
        end
        drive(0,0,0,0,0,0,0,0);
        chk("after_wrap_pc", fetch_pc_o, 32'h4);
`ifdef FETCH_PERF_CNT_EN
        exp_hits = 32'd4; exp_redirs = 32'd7;
`else
        exp_hits = 32'd0; exp_redirs = 32'd0;
`endif
        chk("perf_hit", perf_hit_cnt_o, exp_hits);
        chk("perf_redir", perf_redir_cnt_o, exp_redirs);

        // Asynchronous reset between clock edges takes effect immediately.
        #2 rst_n = 1'b0;
        #1;
        chk("midreset_pc", fetch_pc_o, 32'h100);
        chk("midreset_valid", {31'b0, fetch_valid_o}, 32'h0);
        chk("midreset_hitcnt", perf_hit_cnt_o, 32'h0);
        chk("midreset_redircnt", perf_redir_cnt_o, 32'h0);
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;

        for (int c = 0; c < 400; c++) begin
            drive($urandom_range(0,5) == 0, $urandom_range(0,1) == 1, $urandom_range(0,7) == 0,
                  32'h100 + $urandom_range(0,255), $urandom_range(0,2) == 0,
                  32'h100 + 4 * $urandom_range(0,47), 32'h100 + $urandom_range(0,255),
                  $urandom_range(0,3) != 0);
            ix    = (m_pc / 4) % 16;
            hit   = m_run && m_v[ix] && (m_tag[ix] == m_pc / 64);
            e_ptk = hit && predict_taken_i;
            e_tgt = hit ? m_tgt[ix] : m_pc + 32'd4;
            #1;
            chk("rnd_pc", fetch_pc_o, m_pc);
            chk("rnd_valid", {31'b0, fetch_valid_o}, {31'b0, m_run});
            chk("rnd_ptaken", {31'b0, pred_taken_o}, {31'b0, e_ptk});
            chk("rnd_ptarget", pred_target_o, e_tgt);
`ifdef FETCH_PERF_CNT_EN
            chk("rnd_hitcnt", perf_hit_cnt_o, m_hit_cnt);
            chk("rnd_redircnt", perf_redir_cnt_o, m_redir_cnt);
`else
            chk("rnd_hitcnt", perf_hit_cnt_o, 32'h0);
            chk("rnd_redircnt", perf_redir_cnt_o, 32'h0);
`endif
            if (m_run) begin
                if (redirect_i)   nxt = redirect_pc_i & ~32'h3;
                else if (stall_i) nxt = m_pc;
                else if (e_ptk)   nxt = e_tgt;
                else              nxt = m_pc + 32'd4;
                if (e_ptk && !stall_i && !redirect_i) m_hit_cnt++;
                if (redirect_i) m_redir_cnt++;
                m_pc = nxt;
            end
            if (upd_valid_i && upd_taken_i) begin
                m_v[(upd_pc_i / 4) % 16]   = 1;
                m_tag[(upd_pc_i / 4) % 16] = upd_pc_i / 64;
                m_tgt[(upd_pc_i / 4) % 16] = upd_target_i & ~32'h3;
            end
            m_run = 1;
            @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
